// File: rtl/pool_pkg.sv
// Shared defaults and types for the 2x2 pooling window generator.
// Optional frame-alignment input is enabled with the macro POOL_WIN_SOF_EN.
package pool_pkg;

    localparam int DATA_W = 8;
    localparam int IMG_W  = 28;
    localparam int IMG_H  = 28;

    // Counter width for a range of v values; never narrower than one bit.
    function automatic int clog2_min1(input int v);
        return (v < 2) ? 1 : $clog2(v);
    endfunction

    localparam int COL_W = clog2_min1(IMG_W);
    localparam int ROW_W = clog2_min1(IMG_H);

    typedef logic [DATA_W-1:0] pix_t;

endpackage

// File: rtl/pool_line_buf.sv
// One-line pixel store: a register array with a synchronous write port and
// two combinational read ports (left and right pixel of a window column pair).
module pool_line_buf
#(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 28,
    parameter int AW     = 5
)
(
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr0,
    input  logic [AW-1:0]     raddr1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1
);
    import pool_pkg::*;

    // Contents are never cleared: every entry is rewritten on the even row
    // before any odd row reads it.
    logic [DATA_W-1:0] mem [IMG_W];

    // Store the incoming even-row pixel at its column.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata0 = mem[raddr0];
    assign rdata1 = mem[raddr1];

endmodule

// File: rtl/pool_window_gen.sv
// Producer side of the 2x2 max-pool interface. Buffers the even row of each
// row pair and emits one non-overlapping 2x2 window per pixel pair on the odd
// row, one cycle after the bottom-right pixel is accepted. No backpressure.
// Macro POOL_WIN_SOF_EN adds in_sof: an accepted beat with in_sof=1 is pixel
// (0,0) and any partial window or frame in progress is dropped.
module pool_window_gen
#(
    parameter int DATA_W = pool_pkg::DATA_W,
    parameter int IMG_W  = pool_pkg::IMG_W,
    parameter int IMG_H  = pool_pkg::IMG_H
)
(
    input  logic              clk,
    input  logic              rst,
`ifdef POOL_WIN_SOF_EN
    input  logic              in_sof,
`endif
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_d1,
    output logic [DATA_W-1:0] out_d2,
    output logic [DATA_W-1:0] out_d3,
    output logic [DATA_W-1:0] out_d4,
    output logic              frame_done
);
    import pool_pkg::*;

    localparam int CW = clog2_min1(IMG_W);
    localparam int RW = clog2_min1(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0]     col, cur_col, raddr0;
    logic [RW-1:0]     row, cur_row;
    logic [DATA_W-1:0] hold, rd0, rd1;
    logic              col_last, row_last, row_odd, col_odd, lb_we;

    // Position of the pixel on in_data; a start-of-frame beat is (0,0).
    always_comb begin
        cur_col = col;
        cur_row = row;
`ifdef POOL_WIN_SOF_EN
        if (in_sof) begin
            cur_col = '0;
            cur_row = '0;
        end
`endif
    end

    assign col_last = (cur_col == COL_LAST);
    assign row_last = (cur_row == ROW_LAST);
    assign row_odd  = cur_row[0];
    assign col_odd  = cur_col[0];
    assign lb_we    = in_valid && !row_odd;
    // Left window column. Equals col-1 whenever a window completes (odd col)
    // and stays inside the array on every other column too.
    assign raddr0   = cur_col & ~CW'(1);

    pool_line_buf #(
        .DATA_W (DATA_W),
        .IMG_W  (IMG_W),
        .AW     (CW)
    ) u_line_buf (
        .clk    (clk),
        .we     (lb_we),
        .waddr  (cur_col),
        .wdata  (in_data),
        .raddr0 (raddr0),
        .raddr1 (cur_col),
        .rdata0 (rd0),
        .rdata1 (rd1)
    );

    // Raster counters, bottom-left hold register and registered window outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            col        <= '0;
            row        <= '0;
            hold       <= '0;
            out_valid  <= 1'b0;
            out_d1     <= '0;
            out_d2     <= '0;
            out_d3     <= '0;
            out_d4     <= '0;
            frame_done <= 1'b0;
        end else begin
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            if (in_valid) begin
                // An unpaired last column on odd-width images never feeds hold.
                if (row_odd && !col_odd && !col_last) begin
                    hold <= in_data;
                end
                if (row_odd && col_odd) begin
                    out_valid <= 1'b1;
                    out_d1    <= rd0;
                    out_d2    <= rd1;
                    out_d3    <= hold;
                    out_d4    <= in_data;
                end
                frame_done <= col_last && row_last;
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : cur_row + 1'b1;
                end else begin
                    col <= cur_col + 1'b1;
                    row <= cur_row;
                end
            end
        end
    end

endmodule

// File: doc/pool_window_gen.md
Name: pool_window_gen

Overview:
- Producer side of the 2x2 max-pool interface.
- Accepts a raster-scan pixel stream, one pixel per accepted beat, from the conv/activation stage.
- Buffers one image line and emits each non-overlapping 2x2 window (stride 2) as four parallel values plus a strobe, wired directly to the pool unit's din1..din4 and en.
- One window per pixel pair on odd rows; no backpressure.

Parameters:
- DATA_W, 8, pixel width in bits
- IMG_W, 28, pixels per line (>=2)
- IMG_H, 28, lines per frame (>=2)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  in_data valid this cycle; pixel accepted when high (no ready, always accepted)
- in_data  in  DATA_W  pixel, raster order, row-major
- out_valid  out  1  window valid strobe (drives pool en)
- out_d1  out  DATA_W  top-left pixel of window
- out_d2  out  DATA_W  top-right pixel
- out_d3  out  DATA_W  bottom-left pixel
- out_d4  out  DATA_W  bottom-right pixel
- frame_done  out  1  one-cycle pulse, last pixel of frame accepted

Behaviour:
- Reset: rst is synchronous, active-high, clock clk. col=0, row=0, out_valid=0, out_d1..out_d4=0, frame_done=0, hold register=0. Line buffer contents are not cleared (don't care).
- Counters: col in 0..IMG_W-1 and row in 0..IMG_H-1 advance only on accepted beats. col wraps to 0 with row+1. row wraps to 0 after the last line. Widths are $clog2 of the respective parameter.
- Even row: line_buf[col] <= in_data.
- Odd row, even col: hold <= in_data.
- Odd row, odd col: window complete. Next cycle: out_valid=1, out_d1=line_buf[col-1], out_d2=line_buf[col], out_d3=hold, out_d4=in_data.
- Latency: 1 cycle from accepting the bottom-right pixel to out_valid.
- out_valid is high exactly one cycle per window. Outputs hold their last values when out_valid=0.
- Odd IMG_W: last column pixels are accepted and counted but never form a window. On odd rows the last column is not written to hold.
- Odd IMG_H: last row pixels are accepted and written to line_buf (harmless) but produce no windows.
- frame_done: registered, high the cycle after accepting the pixel at (IMG_H-1, IMG_W-1). It coincides with out_valid when both dimensions are even.
- in_valid gaps: state is frozen. No output changes except out_valid/frame_done dropping to 0.
- Reset mid-frame: the next accepted pixel is (0,0). No window from the partial frame is emitted after reset.
- Windows per frame: (IMG_W/2)*(IMG_H/2), using integer division.

Optional Feature:
- Macro POOL_WIN_SOF_EN.
- Defined: adds input in_sof (1 bit). An accepted beat with in_sof=1 is treated as pixel (0,0): counters are forced so that this pixel is stored as col=0, row=0 and the next beat is col=1. Any partial window in progress is abandoned silently. frame_done is not pulsed for the aborted frame.
- Not defined: port absent; frame alignment comes from reset and counting only.

Decomposition:
- Package pool_pkg: DATA_W, IMG_W, IMG_H defaults, COL_W/ROW_W localparams ($clog2), pixel typedef pix_t (logic [DATA_W-1:0]).
- One sub-module, pool_line_buf: IMG_W x DATA_W register array, synchronous write (we, waddr, wdata), two combinational read ports (raddr0 = col-1, raddr1 = col).
- Counters, hold register and output registers stay in the top level.

Test Plan:
- Basic, IMG_W=4, IMG_H=4, pixels 0..15 with continuous in_valid -> out_valid 4 times with (d1,d2,d3,d4) = (0,1,4,5), (2,3,6,7), (8,9,12,13), (10,11,14,15). frame_done pulses once, together with the last window.
- Odd dimensions, IMG_W=5, IMG_H=3, pixels 0..14 -> windows (0,1,5,6), (2,3,7,8) only. frame_done follows pixel 14 with out_valid=0.
- Gapped input, 4x4 config, in_valid toggling 1,0,0,1,... -> same four windows and values as the basic test. Each out_valid comes exactly 1 cycle after pixels 5, 7, 13, 15 are accepted.
- Back-to-back frames, 4x4, pixels 0..15 then 16..31 -> second frame windows (16,17,20,21) ... (26,27,30,31). No window straddles the frame boundary.
- Reset mid-frame, 4x4: send 0..6, assert rst for 1 cycle, then send 100..115 -> only windows (100,101,104,105), (102,103,106,107), (108,109,112,113), (110,111,114,115). All outputs are 0 during and right after rst.
- POOL_WIN_SOF_EN, 4x4: send 0..5, then 50..65 with in_sof=1 on 50 -> windows (50,51,54,55) etc. No frame_done for the aborted frame.
